rect_stream_dma: RTL
====================

Name: rect_stream_dma

Overview:
- Second-generation rectangle DMA engine.
- On a start pulse it walks RECT_COUNT six-word rectangle records in data memory. Each record is flags, x, y, width, height, color.
- Relative x/y are converted to absolute using a cursor. Hidden rectangles are skipped. Visible rectangles go out as 6-word packets on a valid/ready stream to the GPU.
- Sits between the data-memory read port and the GPU rectangle loader. Unlike its predecessor it tolerates GPU backpressure and reports completion.

Parameters:
- COORD_WIDTH, 16, width of x/y/width/height arithmetic (1..16).
- ADDR_WIDTH, `DATA_ADDR_WIDTH, data-memory address width.
- RECT_ADDR, `RECT_MEM, word address of record 0.
- RECT_COUNT, 64, number of records walked per frame (1..2^(ADDR_WIDTH)/6).
- CNT_WIDTH, $clog2(RECT_COUNT+1), width of record and emitted counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- copy_start  in  1  single-cycle start request; ignored unless idle.
- mem_rd_en  out  1  read strobe to data memory.
- mem_rd_addr  out  ADDR_WIDTH  read address; data returns next cycle.
- mem_rd_data  in  16  read data, valid the cycle after mem_rd_en.
- out_valid  out  1  stream word valid.
- out_ready  in  1  GPU accepts word when out_valid&out_ready.
- out_data  out  16  stream word.
- out_last  out  1  high on word 5 of the final emitted packet.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the frame is finished.
- rect_emitted  out  CNT_WIDTH  visible rectangles emitted in the last or current frame.

Behaviour:
Reset values:
- out_valid=0, out_last=0, busy=0, done=0, mem_rd_en=0.
- mem_rd_addr=RECT_ADDR, rect_emitted=0, cursor_x=cursor_y=0.
- State IDLE, output FIFO empty.

Record format:
- flags bit0=ABS (x/y are absolute and are loaded into the cursor).
- flags bit1=HIDE (do not emit). Other bits are ignored.

States:
- IDLE: on copy_start, busy<=1, rect_emitted<=0, rec_idx<=0, base<=RECT_ADDR, go to RD_FLAGS next cycle.
- RD_FLAGS: issue read of base+0, go to WAIT_FLAGS.
- WAIT_FLAGS: capture flags from mem_rd_data.
  - Visible: go to RD_FIELDS with field index 1..5.
  - HIDE&ABS: go to RD_FIELDS with field index 1..2 only.
  - HIDE&!ABS: go to NEXT.
  - Visible also pushes header word 16'h0000 into the FIFO, and this push waits for FIFO space.
- RD_FIELDS: issue one read per cycle, only while credits allow; go to NEXT after the last field read's data returns.
- NEXT: base<=base+6, rec_idx<=rec_idx+1. If rec_idx==RECT_COUNT-1, go to DRAIN; else go to RD_FLAGS.
- DRAIN: wait until FIFO empty, then pulse done, busy<=0, go to IDLE.

Field processing (data cycle):
- x/y with ABS: cursor<=field[COORD_WIDTH-1:0]; out word = field.
- x/y without ABS: out word = zero-extend((cursor+field) mod 2^COORD_WIDTH); cursor unchanged.
- width/height: out word = zero-extend(field[COORD_WIDTH-1:0]).
- color: passed as full 16 bits.
- A hidden record updates the cursor but pushes nothing.

Flow control:
- 2-entry output FIFO. A read is issued only if FIFO occupancy + in-flight reads < 2. Returning data therefore never overflows.
- out_valid = FIFO non-empty; out_data = head.
- With out_ready held high, sustained throughput is 1 word/cycle after the flags bubble.
- out_valid/out_data hold stable while out_ready=0.

Counters and flags:
- rect_emitted increments when a visible packet's color word is pushed. It saturates at RECT_COUNT by construction.
- out_last is set on the color word of the last visible record. The final visibility decision is made when that word is pushed: if no later record is visible, a marker is stored with the FIFO entry. Implement by deferring the last flag: the color word is not released from the FIFO head until the next visible header is pushed or DRAIN is reached.
- All records hidden: no words emitted, done still pulses.

Other rules:
- copy_start while busy: ignored, no restart.
- Reset mid-frame: immediate abort, FIFO flushed, no done pulse.
- Record address arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- Single visible ABS record {1,10,20,30,40,0xF00F}, RECT_COUNT=1, out_ready=1 -> stream 0,10,20,30,40,0xF00F. out_last on word 5, done one cycle after the last handshake, rect_emitted=1.
- Rec0 {1,100,50,8,8,c0}, rec1 {0,5,0xFFFF,2,2,c1} -> packet1 x=105, y=49 (16-bit wrap). Cursor stays at (100,50).
- COORD_WIDTH=10, relative x 1000+100 -> 76. Width 0x0FFF -> 0x3FF.
- Rec0 {3,200,200,...} hidden ABS, rec1 {0,1,1,...} visible -> only one packet, x=201, y=201. Hidden record emits nothing.
- out_ready toggled by a random 30% duty over 64 records -> no word lost or duplicated. out_data stable while stalled. Total words = 6·visible.
- Reset asserted mid-record 10, then copy_start -> out_valid drops asynchronously. The new frame restarts at RECT_ADDR with cursor (0,0). Second copy_start while busy is ignored.

Source files
------------

// File: rtl/rect_stream_dma_if.sv
// rect_stream_dma_if: data-memory read port plus the GPU word stream.
// master = DMA side (drives read strobe/address and stream), slave = memory/GPU side.
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 16
`endif

interface rect_stream_dma_if #(
    parameter int ADDR_WIDTH = `DATA_ADDR_WIDTH
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [15:0]           mem_rd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_data;
    logic                  out_last;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/rect_stream_dma.sv
// rect_stream_dma: walks RECT_COUNT six-word rectangle records, resolves relative
// coordinates against a cursor and streams visible rectangles as 6-word packets.
// Ports: clk, reset (async high), copy_start, bus (memory read + stream, master),
//        busy, done (1-cycle pulse), rect_emitted (visible packets this frame).
`ifndef DATA_ADDR_WIDTH
`define DATA_ADDR_WIDTH 16
`endif
`ifndef RECT_MEM
`define RECT_MEM 'h0100
`endif

module rect_stream_dma #(
    parameter int                    COORD_WIDTH = 16,
    parameter int                    ADDR_WIDTH  = `DATA_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RECT_ADDR   = ADDR_WIDTH'(`RECT_MEM),
    parameter int                    RECT_COUNT  = 64,
    parameter int                    CNT_WIDTH   = $clog2(RECT_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 copy_start,
    rect_stream_dma_if.master    bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] rect_emitted
);

    typedef enum logic [2:0] {
        IDLE,
        RD_FLAGS,
        WAIT_FLAGS,
        HDR,
        RD_FIELDS,
        NEXT,
        DRAIN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(RECT_COUNT - 1);

    state_t                 state, state_n;
    logic [ADDR_WIDTH-1:0]  base;
    logic [CNT_WIDTH-1:0]   rec_idx;
    logic [2:0]             fld_rd;
    logic [2:0]             fld_rx;
    logic [2:0]             last_fld;
    logic                   vis, abs_f;
    logic                   rd_pend;
    logic [COORD_WIDTH-1:0] cur_x, cur_y;
    logic [COORD_WIDTH-1:0] fld_c, sum_x, sum_y;

    logic [15:0]            fifo [2];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             count;
    // Set while the newest FIFO entry is a colour word whose out_last is
    // still undecided; it may only leave once that decision is known.
    logic                   hold;

    logic                   pop, push, hdr_push, fld_push, fld_issue, color_push;
    logic                   rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [2:0]             occ_n;
    logic [15:0]            fld_word, push_data;

    assign fld_c = bus.mem_rd_data[COORD_WIDTH-1:0];
    assign sum_x = cur_x + fld_c;
    assign sum_y = cur_y + fld_c;

    always_comb begin
        unique case (fld_rx)
            3'd1:    fld_word = abs_f ? bus.mem_rd_data : 16'(sum_x);
            3'd2:    fld_word = abs_f ? bus.mem_rd_data : 16'(sum_y);
            3'd5:    fld_word = bus.mem_rd_data;
            default: fld_word = 16'(fld_c);
        endcase
    end

    assign bus.out_valid = (count != 2'd0) &&
                           !(hold && count == 2'd1 && state != DRAIN);
    assign bus.out_last  = bus.out_valid && hold && count == 2'd1;
    assign bus.out_data  = fifo[rd_ptr];
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_rd_addr = rd_addr;

    assign pop        = bus.out_valid && bus.out_ready;
    assign push       = hdr_push || fld_push;
    assign push_data  = fld_push ? fld_word : 16'h0000;
    assign color_push = fld_push && fld_rx == 3'd5;
    assign busy       = (state != IDLE);

    always_comb begin
        state_n   = state;
        rd_en     = 1'b0;
        rd_addr   = base;
        hdr_push  = 1'b0;
        fld_push  = 1'b0;
        fld_issue = 1'b0;
        done      = 1'b0;
        occ_n     = 3'd0;
        unique case (state)
            IDLE: begin
                if (copy_start) state_n = RD_FLAGS;
            end
            RD_FLAGS: begin
                rd_en   = 1'b1;
                state_n = WAIT_FLAGS;
            end
            WAIT_FLAGS: begin
                if (!bus.mem_rd_data[1]) begin
                    if (count != 2'd2 || pop) begin
                        hdr_push = 1'b1;
                        state_n  = RD_FIELDS;
                    end else begin
                        state_n  = HDR;
                    end
                end else if (bus.mem_rd_data[0]) begin
                    state_n = RD_FIELDS;
                end else begin
                    state_n = NEXT;
                end
            end
            HDR: begin
                if (count != 2'd2 || pop) begin
                    hdr_push = 1'b1;
                    state_n  = RD_FIELDS;
                end
            end
            RD_FIELDS: begin
                fld_push = rd_pend && vis;
                // Occupancy next cycle; a new read lands then and must fit.
                occ_n = 3'(count) + 3'(fld_push) - 3'(pop);
                if (rd_pend && fld_rx == last_fld) begin
                    state_n = NEXT;
                end else if (fld_rd <= last_fld && occ_n < 3'd2) begin
                    fld_issue = 1'b1;
                    rd_en     = 1'b1;
                    rd_addr   = base + ADDR_WIDTH'(fld_rd);
                end
            end
            NEXT: begin
                state_n = (rec_idx == LAST_IDX) ? DRAIN : RD_FLAGS;
            end
            DRAIN: begin
                if (count == 2'd0) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            base         <= RECT_ADDR;
            rec_idx      <= '0;
            fld_rd       <= 3'd1;
            fld_rx       <= 3'd1;
            last_fld     <= 3'd5;
            vis          <= 1'b0;
            abs_f        <= 1'b0;
            rd_pend      <= 1'b0;
            cur_x        <= '0;
            cur_y        <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            hold         <= 1'b0;
            rect_emitted <= '0;
        end else begin
            state   <= state_n;
            rd_pend <= fld_issue;
            if (state == IDLE && copy_start) begin
                rec_idx      <= '0;
                base         <= RECT_ADDR;
                rect_emitted <= '0;
            end
            if (state == WAIT_FLAGS) begin
                vis      <= ~bus.mem_rd_data[1];
                abs_f    <= bus.mem_rd_data[0];
                fld_rd   <= 3'd1;
                last_fld <= bus.mem_rd_data[1] ? 3'd2 : 3'd5;
            end
            if (fld_issue) begin
                fld_rd <= fld_rd + 3'd1;
                fld_rx <= fld_rd;
            end
            if (state == RD_FIELDS && rd_pend && abs_f) begin
                if (fld_rx == 3'd1) cur_x <= fld_c;
                if (fld_rx == 3'd2) cur_y <= fld_c;
            end
            if (state == NEXT) begin
                base    <= base + ADDR_WIDTH'(6);
                rec_idx <= rec_idx + 1'b1;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
            if (color_push) begin
                hold         <= 1'b1;
                rect_emitted <= rect_emitted + 1'b1;
            end else if (hdr_push || (pop && count == 2'd1)) begin
                hold <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= push_data;
    end

endmodule
